// File: rtl/universal_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : universal_shift_reg_pkg
//  Description : Shared constants for the universal shift register: the
//                operation-select encodings used by the RTL and its bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package universal_shift_reg_pkg;

    localparam int c_MODE_W = 2;

    localparam logic [c_MODE_W-1:0] MODE_HOLD = 2'b00;
    localparam logic [c_MODE_W-1:0] MODE_SHR  = 2'b01;
    localparam logic [c_MODE_W-1:0] MODE_SHL  = 2'b10;
    localparam logic [c_MODE_W-1:0] MODE_LOAD = 2'b11;

    // True for the two modes that move data and therefore advance the count
    function automatic logic is_shift(input logic [c_MODE_W-1:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage : universal_shift_reg_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that stops at MAX instead of wrapping. A clear
//                returns it to zero; reset has priority over everything.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] c_MAX = W'(MAX);

    logic [W-1:0] r_count;

    // Count register: reset/clear to zero, otherwise increment until MAX
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/universal_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : universal_shift_reg
//  Description : Hold / shift-right / shift-left / parallel-load register with
//                optional rotate, serial-out of the last bit moved out, and a
//                saturating count of shifts since the last load or reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_reg
    import universal_shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             w_in_r;
    logic             w_in_l;
    logic             w_load;
    logic             w_shift;
    logic [CW-1:0]    w_cnt;

    // In rotate mode the bit falling off one end re-enters at the other
    assign w_in_r  = rot ? r_q[0]       : sin_r;
    assign w_in_l  = rot ? r_q[WIDTH-1] : sin_l;
    assign w_load  = (mode == MODE_LOAD);
    assign w_shift = is_shift(mode);

    // Data and serial-out register; reset beats every mode including load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= RESET_VAL;
            r_sout <= 1'b0;
        end else begin
            case (mode)
                MODE_SHR: begin
                    r_q    <= {w_in_r, r_q[WIDTH-1:1]};
                    r_sout <= r_q[0];
                end
                MODE_SHL: begin
                    r_q    <= {r_q[WIDTH-2:0], w_in_l};
                    r_sout <= r_q[WIDTH-1];
                end
                MODE_LOAD: begin
                    r_q    <= d;
                    r_sout <= 1'b0;
                end
                default: begin
                    r_q    <= r_q;
                    r_sout <= r_sout;
                end
            endcase
        end
    end

    sat_counter #(
        .MAX (WIDTH),
        .W   (CW)
    ) u_sat_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (w_load),
        .inc   (w_shift),
        .count (w_cnt)
    );

    assign q    = r_q;
    assign sout = r_sout;
    assign cnt  = w_cnt;
    // Decoded straight from the registered count, so it is 0 once reset lands
    assign done = (w_cnt == CW'(WIDTH));

endmodule : universal_shift_reg
`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_universal_shift_reg
//  Description : Directed self-checking bench for universal_shift_reg with
//                WIDTH=4; a second instance uses RESET_VAL=4'b1001.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_reg;
    import universal_shift_reg_pkg::*;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          rot;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  d;
    logic [W-1:0]  q,  q2;
    logic          sout, sout2;
    logic [CW-1:0] cnt, cnt2;
    logic          done, done2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
        .clk(clk), .rst(rst), .mode(mode), .rot(rot), .sin_r(sin_r),
        .sin_l(sin_l), .d(d), .q(q), .sout(sout), .cnt(cnt), .done(done)
    );

    universal_shift_reg #(.WIDTH(W), .RESET_VAL(4'b1001)) dut2 (
        .clk(clk), .rst(rst), .mode(mode), .rot(rot), .sin_r(sin_r),
        .sin_l(sin_l), .d(d), .q(q2), .sout(sout2), .cnt(cnt2), .done(done2)
    );

    // Apply one set of inputs across a single rising edge, sample 1 time unit later
    task automatic step(input logic r, input logic [1:0] m, input logic ro,
                        input logic sr, input logic sl, input logic [W-1:0] dd);
        rst = r; mode = m; rot = ro; sin_r = sr; sin_l = sl; d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // reset wins over a simultaneous load of all-ones
        step(1'b1, MODE_LOAD, 1'b0, 1'b0, 1'b0, 4'b1111);
        n_vec++;
        if ({q, sout, cnt, done} !== {4'b0000, 1'b0, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_over_load: got q=%b sout=%b cnt=%0d done=%b, want q=0000 sout=0 cnt=0 done=0", q, sout, cnt, done);
        end
        n_vec++;
        if (q2 !== 4'b1001) begin
            n_err++;
            $display("FAIL reset_val_1001: got q=%b, want q=1001", q2);
        end
        step(1'b1, MODE_SHR, 1'b0, 1'b1, 1'b0, 4'b0000);
        n_vec++;
        if ({q, cnt, done} !== {4'b0000, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_hold_shift: got q=%b cnt=%0d done=%b, want q=0000 cnt=0 done=0", q, cnt, done);
        end
    endtask

    task automatic test_load();
        step(1'b0, MODE_LOAD, 1'b0, 1'b0, 1'b0, 4'b1010);
        n_vec++;
        if ({q, sout, cnt, done} !== {4'b1010, 1'b0, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL load_1010: got q=%b sout=%b cnt=%0d done=%b, want q=1010 sout=0 cnt=0 done=0", q, sout, cnt, done);
        end
    endtask

    task automatic test_shift();
        step(1'b0, MODE_SHR, 1'b0, 1'b1, 1'b0, 4'b0000);
        n_vec++;
        if ({q, sout, cnt} !== {4'b1101, 1'b0, 3'd1}) begin
            n_err++;
            $display("FAIL shr_sin1: got q=%b sout=%b cnt=%0d, want q=1101 sout=0 cnt=1", q, sout, cnt);
        end
        step(1'b0, MODE_SHL, 1'b0, 1'b1, 1'b0, 4'b0000);
        n_vec++;
        if ({q, sout, cnt} !== {4'b1010, 1'b1, 3'd2}) begin
            n_err++;
            $display("FAIL shl_sin0: got q=%b sout=%b cnt=%0d, want q=1010 sout=1 cnt=2", q, sout, cnt);
        end
    endtask

    task automatic test_rotate();
        logic [W-1:0] exp_q [4] = '{4'b0101, 4'b1010, 4'b0101, 4'b1010};
        logic         exp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        step(1'b0, MODE_LOAD, 1'b0, 1'b0, 1'b0, 4'b1010);
        // serial inputs held at 1 to show rotate ignores them
        for (int i = 0; i < 4; i++) begin
            step(1'b0, MODE_SHR, 1'b1, 1'b1, 1'b1, 4'b0000);
            n_vec++;
            if ({q, sout, cnt, done} !== {exp_q[i], exp_s[i], 3'(i + 1), (i == 3)}) begin
                n_err++;
                $display("FAIL rotr_%0d: got q=%b sout=%b cnt=%0d done=%b, want q=%b sout=%b cnt=%0d done=%b",
                         i, q, sout, cnt, done, exp_q[i], exp_s[i], i + 1, (i == 3));
            end
        end
        step(1'b0, MODE_SHR, 1'b1, 1'b0, 1'b0, 4'b0000);
        n_vec++;
        if ({q, sout, cnt, done} !== {4'b0101, 1'b0, 3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL rotr_saturate: got q=%b sout=%b cnt=%0d done=%b, want q=0101 sout=0 cnt=4 done=1", q, sout, cnt, done);
        end
        step(1'b0, MODE_SHL, 1'b1, 1'b0, 1'b1, 4'b0000);
        n_vec++;
        if ({q, sout, cnt, done} !== {4'b1010, 1'b0, 3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL rotl_saturate: got q=%b sout=%b cnt=%0d done=%b, want q=1010 sout=0 cnt=4 done=1", q, sout, cnt, done);
        end
        step(1'b0, MODE_SHL, 1'b0, 1'b0, 1'b1, 4'b0000);
        n_vec++;
        if ({q, sout, cnt, done} !== {4'b0101, 1'b1, 3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL shl_saturate: got q=%b sout=%b cnt=%0d done=%b, want q=0101 sout=1 cnt=4 done=1", q, sout, cnt, done);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, MODE_HOLD, 1'b1, 1'b1, 1'b1, 4'b1111);
            n_vec++;
            if ({q, sout, cnt, done} !== {4'b0101, 1'b1, 3'd4, 1'b1}) begin
                n_err++;
                $display("FAIL hold_%0d: got q=%b sout=%b cnt=%0d done=%b, want q=0101 sout=1 cnt=4 done=1", i, q, sout, cnt, done);
            end
        end
        // rot is irrelevant to load
        step(1'b0, MODE_LOAD, 1'b1, 1'b1, 1'b1, 4'b0110);
        n_vec++;
        if ({q, sout, cnt, done} !== {4'b0110, 1'b0, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL load_0110: got q=%b sout=%b cnt=%0d done=%b, want q=0110 sout=0 cnt=0 done=0", q, sout, cnt, done);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, MODE_SHR, 1'b0, 1'b0, 1'b0, 4'b0000);
        step(1'b0, MODE_SHR, 1'b0, 1'b0, 1'b0, 4'b0000);
        n_vec++;
        if ({q, sout, cnt} !== {4'b0001, 1'b1, 3'd2}) begin
            n_err++;
            $display("FAIL two_shifts: got q=%b sout=%b cnt=%0d, want q=0001 sout=1 cnt=2", q, sout, cnt);
        end
        step(1'b1, MODE_SHR, 1'b0, 1'b1, 1'b0, 4'b0000);
        n_vec++;
        if ({q, sout, cnt, done} !== {4'b0000, 1'b0, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset: got q=%b sout=%b cnt=%0d done=%b, want q=0000 sout=0 cnt=0 done=0", q, sout, cnt, done);
        end
        step(1'b0, MODE_SHR, 1'b0, 1'b1, 1'b0, 4'b0000);
        n_vec++;
        if ({q, sout, cnt} !== {4'b1000, 1'b0, 3'd1}) begin
            n_err++;
            $display("FAIL post_reset_shr: got q=%b sout=%b cnt=%0d, want q=1000 sout=0 cnt=1", q, sout, cnt);
        end
        n_vec++;
        if ({q2, sout2, cnt2} !== {4'b1100, 1'b1, 3'd1}) begin
            n_err++;
            $display("FAIL post_reset_shr_rv1001: got q=%b sout=%b cnt=%0d, want q=1100 sout=1 cnt=1", q2, sout2, cnt2);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, MODE_SHL, 1'b0, 1'b0, 1'b1, 4'b0000);
        n_vec++;
        if ({q, sout, cnt} !== {4'b0001, 1'b1, 3'd2}) begin
            n_err++;
            $display("FAIL b2b_shl: got q=%b sout=%b cnt=%0d, want q=0001 sout=1 cnt=2", q, sout, cnt);
        end
        step(1'b0, MODE_LOAD, 1'b0, 1'b0, 1'b0, 4'b1111);
        n_vec++;
        if ({q, sout, cnt} !== {4'b1111, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL b2b_load: got q=%b sout=%b cnt=%0d, want q=1111 sout=0 cnt=0", q, sout, cnt);
        end
        step(1'b0, MODE_SHL, 1'b0, 1'b1, 1'b0, 4'b0000);
        n_vec++;
        if ({q, sout, cnt} !== {4'b1110, 1'b1, 3'd1}) begin
            n_err++;
            $display("FAIL b2b_shl_after_load: got q=%b sout=%b cnt=%0d, want q=1110 sout=1 cnt=1", q, sout, cnt);
        end
    endtask

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion before 100000");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mode = MODE_HOLD; rot = 1'b0; sin_r = 1'b0; sin_l = 1'b0; d = '0;
        @(negedge clk);
        test_reset();
        test_load();
        test_shift();
        test_rotate();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_universal_shift_reg
`default_nettype wire
